// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared debouncer state encoding and sizing helper
//
// Purpose: state constants for the per-channel debounce FSM and the
//          counter-width helper used by debounce_channel.
// Contents:
//   db_state_e   - 2-bit FSM state (STABLE_LO, PEND_HI, STABLE_HI, PEND_LO)
//   db_cnt_width - width of the per-channel qualification counter
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    PEND_HI   = 2'b01,
    STABLE_HI = 2'b10,
    PEND_LO   = 2'b11
  } db_state_e;

  // Counter must hold 0..stable_cnt-1; never narrower than one bit.
  function automatic int db_cnt_width(input int stable_cnt);
    int w;
    w = $clog2(stable_cnt);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one debounce channel: synchronizer, FSM, counter
//
// Purpose: synchronizes one raw input, qualifies level changes over
//          STABLE_CNT consecutive sample ticks and produces registered
//          level / edge-pulse / toggle outputs.
// Ports:
//   clk      - rising-edge clock
//   rst_a_n  - asynchronous active-low reset
//   tick     - shared sample strobe; FSM and counter advance only on it
//   din      - raw asynchronous input
//   tog_clr  - synchronous clear of toggle (wins over a coinciding rise)
//   level    - debounced level
//   rise     - one-cycle pulse when level first shows 1
//   fall     - one-cycle pulse when level first shows 0
//   toggle   - inverts after every rise pulse
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_CNT = 4
) (
  input  logic clk,
  input  logic rst_a_n,
  input  logic tick,
  input  logic din,
  input  logic tog_clr,
  output logic level,
  output logic rise,
  output logic fall,
  output logic toggle
);

  localparam int            CW      = db_cnt_width(STABLE_CNT);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          sync1_q,  sync1_d;
  logic          sync2_q,  sync2_d;
  db_state_e     state_q,  state_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic          level_q,  level_d;
  logic          rise_q,   rise_d;
  logic          fall_q,   fall_d;
  logic          toggle_q, toggle_d;

  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
  end

  // Next-state logic. Entering a pending state counts the current tick as
  // the first agreeing sample, so STABLE_CNT agreeing ticks accept.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (tick) begin
      case (state_q)
        STABLE_LO: begin
          if (sync2_q) begin
            state_d = PEND_HI;
            cnt_d   = CNT_ONE;
          end
        end
        PEND_HI: begin
          if (!sync2_q) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        STABLE_HI: begin
          if (!sync2_q) begin
            state_d = PEND_LO;
            cnt_d   = CNT_ONE;
          end
        end
        PEND_LO: begin
          if (sync2_q) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Level and edge pulses are derived from the next state so they land in
  // the same cycle as the state change.
  always_comb begin
    level_d  = (state_d == STABLE_HI) || (state_d == PEND_LO);
    rise_d   = level_d & ~level_q;
    fall_d   = ~level_d & level_q;
    toggle_d = tog_clr ? 1'b0 : (toggle_q ^ rise_q);
  end

  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      state_q  <= STABLE_LO;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      toggle_q <= toggle_d;
    end
  end

  assign level  = level_q;
  assign rise   = rise_q;
  assign fall   = fall_q;
  assign toggle = toggle_q;

endmodule

// File: rtl/multi_debouncer.sv
// rtl/multi_debouncer.sv - N-channel debouncer with shared sample prescaler
//
// Purpose: one prescaler generating a sample tick every TICK_DIV cycles,
//          shared by N_CH independent debounce channels.
// Ports:
//   clk       - rising-edge clock
//   rst_a_n   - asynchronous active-low reset
//   db_in     - raw asynchronous inputs, one per channel
//   tog_clr   - per-channel synchronous clear of db_toggle
//   db_level  - debounced levels
//   db_rise   - one-cycle pulses on accepted 0->1 changes
//   db_fall   - one-cycle pulses on accepted 1->0 changes
//   db_toggle - per-channel toggle, flips on every rise
//   tick      - shared sample strobe
module multi_debouncer
  import debounce_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int TICK_DIV   = 5000,
  parameter int STABLE_CNT = 4
) (
  input  logic            clk,
  input  logic            rst_a_n,
  input  logic [N_CH-1:0] db_in,
  input  logic [N_CH-1:0] tog_clr,
  output logic [N_CH-1:0] db_level,
  output logic [N_CH-1:0] db_rise,
  output logic [N_CH-1:0] db_fall,
  output logic [N_CH-1:0] db_toggle,
  output logic            tick
);

  localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q,  tick_d;

  // tick is registered from the next count so it is high exactly while the
  // count sits at TICK_DIV-1 (always, when TICK_DIV is 1) and 0 in reset.
  always_comb begin
    presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
    tick_d  = (presc_d == PRESC_MAX);
  end

  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .STABLE_CNT (STABLE_CNT)
    ) u_ch (
      .clk     (clk),
      .rst_a_n (rst_a_n),
      .tick    (tick_q),
      .din     (db_in[g]),
      .tog_clr (tog_clr[g]),
      .level   (db_level[g]),
      .rise    (db_rise[g]),
      .fall    (db_fall[g]),
      .toggle  (db_toggle[g])
    );
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// tb/tb_multi_debouncer.sv - directed self-checking bench for multi_debouncer
module tb_multi_debouncer;

  logic       clk;
  logic       rst_a_n;
  logic [3:0] db_in, tog_clr, db_level, db_rise, db_fall, db_toggle;
  logic       tick;

  logic       rst_b_n;
  logic [0:0] b_in, b_clr, b_level, b_rise, b_fall, b_toggle;
  logic       b_tick;

  int checks, errors;
  int cyc, cyc0, lat;
  int rise_cnt [4];
  int fall_cnt [4];
  int rise_cyc [4];
  int tick_cnt;
  int b_rise_cnt, b_fall_cnt, b_rise_cyc, b_tick_cnt;

  multi_debouncer #(.N_CH(4), .TICK_DIV(4), .STABLE_CNT(3)) u_dut (
    .clk       (clk),
    .rst_a_n   (rst_a_n),
    .db_in     (db_in),
    .tog_clr   (tog_clr),
    .db_level  (db_level),
    .db_rise   (db_rise),
    .db_fall   (db_fall),
    .db_toggle (db_toggle),
    .tick      (tick)
  );

  multi_debouncer #(.N_CH(1), .TICK_DIV(1), .STABLE_CNT(2)) u_dut_b (
    .clk       (clk),
    .rst_a_n   (rst_b_n),
    .db_in     (b_in),
    .tog_clr   (b_clr),
    .db_level  (b_level),
    .db_rise   (b_rise),
    .db_fall   (b_fall),
    .db_toggle (b_toggle),
    .tick      (b_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample_outputs();
    cyc++;
    for (int c = 0; c < 4; c++) begin
      if (db_rise[c]) begin
        rise_cnt[c]++;
        if (rise_cyc[c] < 0) rise_cyc[c] = cyc;
      end
      if (db_fall[c]) fall_cnt[c]++;
    end
    if (tick) tick_cnt++;
    if (b_rise[0]) begin
      b_rise_cnt++;
      if (b_rise_cyc < 0) b_rise_cyc = cyc;
    end
    if (b_fall[0]) b_fall_cnt++;
    if (b_tick) b_tick_cnt++;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      sample_outputs();
    end
  endtask

  task automatic clear_counts();
    for (int c = 0; c < 4; c++) begin
      rise_cnt[c] = 0;
      fall_cnt[c] = 0;
      rise_cyc[c] = -1;
    end
    tick_cnt   = 0;
    b_rise_cnt = 0;
    b_fall_cnt = 0;
    b_rise_cyc = -1;
    b_tick_cnt = 0;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    db_in   = '0;
    tog_clr = '0;
    b_in    = '0;
    b_clr   = '0;
    clear_counts();
    step(3);

    // reset state
    check("rst_level",  32'(db_level),  32'h0);
    check("rst_rise",   32'(db_rise),   32'h0);
    check("rst_fall",   32'(db_fall),   32'h0);
    check("rst_toggle", 32'(db_toggle), 32'h0);
    check("rst_tick",   32'(tick),      32'h0);
    check("rst_b_tick", 32'(b_tick),    32'h0);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    step(2);

    // clean step on ch0
    clear_counts();
    db_in[0] = 1'b1;
    cyc0 = cyc;
    step(20);
    lat = rise_cyc[0] - cyc0;
    check($sformatf("step_lat_ch0_%0d", lat), 32'(lat >= 11 && lat <= 15), 32'h1);
    check("step_level0",  32'(db_level[0]), 32'h1);
    check("step_rise0",   32'(rise_cnt[0]), 32'd1);
    check("step_toggle0", 32'(db_toggle[0]), 32'h1);
    check("step_quiet",   32'(rise_cnt[1] + rise_cnt[2] + rise_cnt[3] + fall_cnt[0]
                              + fall_cnt[1] + fall_cnt[2] + fall_cnt[3]), 32'd0);
    check("tick_count",   32'(tick_cnt), 32'd5);

    // bounce on ch1
    clear_counts();
    db_in[1] = 1'b1;
    step(6);
    db_in[1] = 1'b0;
    step(6);
    db_in[1] = 1'b1;
    cyc0 = cyc;
    step(10);
    check("bounce_no_early_rise",  32'(rise_cnt[1]), 32'd0);
    check("bounce_no_early_level", 32'(db_level[1]), 32'h0);
    step(10);
    lat = rise_cyc[1] - cyc0;
    check($sformatf("bounce_lat_%0d", lat), 32'(lat >= 11 && lat <= 15), 32'h1);
    check("bounce_rise1",   32'(rise_cnt[1]), 32'd1);
    check("bounce_fall1",   32'(fall_cnt[1]), 32'd0);
    check("bounce_level1",  32'(db_level[1]), 32'h1);
    check("bounce_toggle1", 32'(db_toggle[1]), 32'h1);

    // three press/release cycles on ch2
    clear_counts();
    for (int i = 0; i < 3; i++) begin
      db_in[2] = 1'b1;
      step(20);
      check($sformatf("press%0d_level2", i), 32'(db_level[2]), 32'h1);
      db_in[2] = 1'b0;
      step(20);
    end
    check("fall_rise2",   32'(rise_cnt[2]), 32'd3);
    check("fall_fall2",   32'(fall_cnt[2]), 32'd3);
    check("fall_level2",  32'(db_level[2]), 32'h0);
    check("fall_toggle2", 32'(db_toggle[2]), 32'h1);
    tog_clr[2] = 1'b1;
    step(1);
    tog_clr[2] = 1'b0;
    step(1);
    check("clr_toggle2",    32'(db_toggle[2]), 32'h0);
    check("clr_keep_tog0",  32'(db_toggle[0]), 32'h1);

    // simultaneous ch0/ch3, clear on ch3 coinciding with its rise
    db_in[0] = 1'b0;
    step(20);
    check("sim_pre_level0", 32'(db_level[0]), 32'h0);
    clear_counts();
    db_in[0] = 1'b1;
    db_in[3] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      tog_clr[3] = db_rise[3];
    end
    tog_clr = '0;
    check("sim_rise0",     32'(rise_cnt[0]), 32'd1);
    check("sim_rise3",     32'(rise_cnt[3]), 32'd1);
    check("sim_same_cyc",  32'(rise_cyc[0]), 32'(rise_cyc[3]));
    check("sim_level3",    32'(db_level[3]), 32'h1);
    check("sim_toggle3",   32'(db_toggle[3]), 32'h0);
    check("sim_toggle0",   32'(db_toggle[0]), 32'h0);

    // reset while ch1 is pending high
    db_in[1] = 1'b0;
    step(20);
    check("rp_pre_level1", 32'(db_level[1]), 32'h0);
    db_in[1] = 1'b1;
    step(6);
    rst_a_n = 1'b0;
    step(2);
    check("rp_level",  32'(db_level),  32'h0);
    check("rp_rise",   32'(db_rise),   32'h0);
    check("rp_fall",   32'(db_fall),   32'h0);
    check("rp_toggle", 32'(db_toggle), 32'h0);
    check("rp_tick",   32'(tick),      32'h0);
    step(1);
    clear_counts();
    rst_a_n = 1'b1;
    cyc0 = cyc;
    step(20);
    lat = rise_cyc[1] - cyc0;
    check($sformatf("rp_lat_ch1_%0d", lat), 32'(lat >= 11 && lat <= 15), 32'h1);
    check("rp_rise1",  32'(rise_cnt[1]), 32'd1);
    check("rp_level1", 32'(db_level[1]), 32'h1);
    check("rp_rise0",  32'(rise_cnt[0]), 32'd1);

    // TICK_DIV=1, STABLE_CNT=2 instance
    clear_counts();
    step(10);
    check("b_tick_const", 32'(b_tick_cnt), 32'd10);
    b_in = 1'b1;
    step(1);
    b_in = 1'b0;
    step(10);
    check("b_glitch_rise",  32'(b_rise_cnt), 32'd0);
    check("b_glitch_fall",  32'(b_fall_cnt), 32'd0);
    check("b_glitch_level", 32'(b_level),    32'h0);
    clear_counts();
    b_in = 1'b1;
    cyc0 = cyc;
    step(10);
    lat = b_rise_cyc - cyc0;
    check($sformatf("b_step_lat_%0d", lat), 32'(lat >= 4 && lat <= 5), 32'h1);
    check("b_step_level", 32'(b_level),    32'h1);
    check("b_step_rise",  32'(b_rise_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
